osc_bitmap_ctrl: RTL and testbench
==================================

Name: osc_bitmap_ctrl

Overview:
- Parametrised page-status bitmap controller between the command sequencer and on-chip SRAM.
- Each flash block owns a BMAP_W-bit bitmap stored as WORDS SRAM words of WORD_W bits. Bit p set means page p is dirty.
- Per command it reads only the words covering a page range [start_page, end_page] and tests, sets, clears or counts the bits in that range.
- For set/clear commands it writes back only the modified words.

Parameters:
- WORD_W, 16, SRAM data width in bits.
- WORDS, 4, SRAM words per block bitmap; power of two, at least 2.
- BLK_AW, 10, block address width.
- Derived: BMAP_W = WORD_W*WORDS; PAGE_W = clog2(BMAP_W); WSEL_W = clog2(WORDS); BSEL_W = clog2(WORD_W).

Ports:
- clk2  in  1  single clock, rising edge
- NReset  in  1  synchronous active-low reset
- op_valid  in  1  command strobe; sampled only in IDLE
- AHOpcode  in  3  000 NOP, 010 CHECK, 001 MARK, 100 ERASE, 011 COUNT; others illegal
- block_address  in  BLK_AW  target block
- start_page  in  PAGE_W  first page of range, inclusive
- end_page  in  PAGE_W  last page of range, inclusive
- Busy  out  1  high whenever state is not IDLE
- Done  out  1  one-cycle completion pulse
- Error  out  1  valid with Done; illegal opcode or start_page > end_page
- Dirty  out  1  registered; any bit set in range before modification
- Count  out  PAGE_W+1  registered; number of set bits in range before modification
- OSAdd  out  BLK_AW+WSEL_W  SRAM address {block_address, word index}
- OSRead  out  1  SRAM read strobe
- OSWrite  out  1  SRAM write strobe
- OSDataout  out  WORD_W  SRAM write data
- OSDatain  in  WORD_W  SRAM read data; valid the cycle after OSRead

Behaviour:
- Reset: sampled on the clk2 rising edge with NReset low. It forces IDLE and clears Busy, Done, Error, Dirty, Count, OSRead, OSWrite, OSDataout and OSAdd.
- Reset mid-operation: aborts immediately. No further SRAM strobes are issued. Words already written back stay written; no Done pulse.
- Command capture: in IDLE with op_valid=1, latch opcode, block_address, start_page and end_page.
  - Inputs are ignored while Busy.
  - Opcode NOP with op_valid returns to IDLE silently.
- Pre-check: illegal opcode or start_page > end_page goes straight to DONE with Error=1. No SRAM access; Dirty and Count are unchanged.
- Word range: words ws = start_page >> BSEL_W through we = end_page >> BSEL_W. Words outside this range are never accessed.
- States: IDLE, RD_REQ, RD_WAIT, EVAL, WR_REQ, WR_GAP, DONE.
- RD_REQ: OSRead=1, OSAdd = {blk, widx}.
- RD_WAIT: OSRead=0. OSDatain is captured into the word register at the end of this cycle.
- EVAL:
  - Build mask m: bit b is set iff widx*WORD_W+b lies in [start_page, end_page].
  - Update accumulators: dirty_acc |= |(w & m); cnt_acc += popcount(w & m).
  - MARK: w' = w | m. ERASE: w' = w & ~m.
  - MARK/ERASE go to WR_REQ. Otherwise, if widx == we go to DONE, else widx++ and go to RD_REQ.
- WR_REQ: OSWrite=1, OSDataout = w', same OSAdd.
- WR_GAP: OSWrite=0. Then DONE if widx == we, else widx++ and RD_REQ.
- Write-back is unconditional for MARK/ERASE, even when w' == w.
- DONE: Done=1 for one cycle. Dirty and Count are loaded from the accumulators (unless Error). Next state IDLE.
- Accumulators clear on command accept. Count saturates at BMAP_W; it cannot exceed this by construction.
- Latency for k = we-ws+1 words, with cycle 1 being the first cycle after the accept edge: Done is high in cycle 3k+1 (CHECK/COUNT) or 5k+1 (MARK/ERASE). Error case: cycle 1.
- OSRead and OSWrite are never high in the same cycle. When neither is asserted, OSAdd holds {blk, widx}.
- Full range (0..BMAP_W-1) touches all WORDS words. A single-page range touches exactly one word.

Test Plan:
- CHECK, blk=5, pages 0..63, bitmap all zero -> 4 reads at addresses 20..23, no writes, Done in cycle 13, Dirty=0, Count=0.
- Preload word1=0x0100. CHECK pages 20..30 -> 1 read at address 21, Done in cycle 4, Dirty=1, Count=1.
- MARK pages 14..17 on a clean block -> reads and writes of word0 then word1. word0 written 0xC000, word1 written 0x0003. Done in cycle 11, Dirty=0.
- ERASE pages 0..63 after the MARK -> all 4 words written 0x0000, Dirty=1, Count=4, Done in cycle 21.
- start_page=9, end_page=3 -> Done and Error in cycle 1, no OSRead/OSWrite. Opcode 111 gives the same response.
- Assert NReset low during WR_GAP of word0 in a 2-word MARK -> next edge all outputs 0, IDLE. Word0 is updated and word1 untouched; a new command is accepted normally after reset release.

Source files
------------

// File: rtl/osc_bitmap_ctrl_if.sv
// Command and SRAM signal bundle for the page-status bitmap controller.
// The controller takes the slave side; the sequencer/SRAM side takes the master side.
interface osc_bitmap_ctrl_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned BLK_AW = 10
);
  localparam int unsigned PAGE_W = $clog2(WORD_W * WORDS);
  localparam int unsigned WSEL_W = $clog2(WORDS);

  logic                      op_valid;
  logic [2:0]                AHOpcode;
  logic [BLK_AW-1:0]         block_address;
  logic [PAGE_W-1:0]         start_page;
  logic [PAGE_W-1:0]         end_page;
  logic                      Busy;
  logic                      Done;
  logic                      Error;
  logic                      Dirty;
  logic [PAGE_W:0]           Count;
  logic [BLK_AW+WSEL_W-1:0]  OSAdd;
  logic                      OSRead;
  logic                      OSWrite;
  logic [WORD_W-1:0]         OSDataout;
  logic [WORD_W-1:0]         OSDatain;

  modport master (
    output op_valid, AHOpcode, block_address, start_page, end_page, OSDatain,
    input  Busy, Done, Error, Dirty, Count, OSAdd, OSRead, OSWrite, OSDataout
  );

  modport slave (
    input  op_valid, AHOpcode, block_address, start_page, end_page, OSDatain,
    output Busy, Done, Error, Dirty, Count, OSAdd, OSRead, OSWrite, OSDataout
  );
endinterface

// File: rtl/osc_bitmap_ctrl.sv
// Page-status bitmap controller: reads the SRAM words covering a page range, then
// tests, counts, sets or clears the range bits, writing back modified words.
module osc_bitmap_ctrl #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned BLK_AW = 10
) (
  input logic              clk2,
  input logic              NReset,
  osc_bitmap_ctrl_if.slave bus
);
  localparam int unsigned BMAP_W = WORD_W * WORDS;
  localparam int unsigned PAGE_W = $clog2(BMAP_W);
  localparam int unsigned WSEL_W = $clog2(WORDS);
  localparam int unsigned BSEL_W = $clog2(WORD_W);

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpMark  = 3'b001;
  localparam logic [2:0] OpCheck = 3'b010;
  localparam logic [2:0] OpCount = 3'b011;
  localparam logic [2:0] OpErase = 3'b100;

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StEval, StWrReq, StWrGap, StDone
  } state_e;

  state_e                   state_q;
  logic [2:0]               op_q;
  logic [BLK_AW-1:0]        blk_q;
  logic [PAGE_W-1:0]        start_q, end_q;
  logic [WSEL_W-1:0]        widx_q, wend_q;
  logic [WORD_W-1:0]        word_q;
  logic                     dirty_acc_q;
  logic [PAGE_W:0]          cnt_acc_q;

  logic                     busy_q, done_q, error_q, dirty_q;
  logic [PAGE_W:0]          count_q;
  logic [BLK_AW+WSEL_W-1:0] os_add_q;
  logic                     os_read_q, os_write_q;
  logic [WORD_W-1:0]        os_dataout_q;

  logic [WORD_W-1:0]        mask, hit, word_new;
  logic [PAGE_W-1:0]        page;
  logic [PAGE_W:0]          pop, cnt_acc_d;
  logic                     dirty_acc_d, is_wb, last_word, cmd_legal;
  logic [WSEL_W-1:0]        ws, we, widx_nxt;

  always_comb begin
    mask = '0;
    page = '0;
    pop  = '0;
    for (int unsigned b = 0; b < WORD_W; b++) begin
      page    = {widx_q, BSEL_W'(b)};
      mask[b] = (page >= start_q) && (page <= end_q);
    end
    hit = word_q & mask;
    for (int unsigned b = 0; b < WORD_W; b++) begin
      pop = pop + (PAGE_W+1)'(hit[b]);
    end
    dirty_acc_d = dirty_acc_q | (|hit);
    cnt_acc_d   = cnt_acc_q + pop;
    word_new    = (op_q == OpMark) ? (word_q | mask) : (word_q & ~mask);
    is_wb       = (op_q == OpMark) || (op_q == OpErase);
    last_word   = (widx_q == wend_q);
    widx_nxt    = widx_q + WSEL_W'(1);
    ws          = bus.start_page[PAGE_W-1:BSEL_W];
    we          = bus.end_page[PAGE_W-1:BSEL_W];
    cmd_legal   = (bus.AHOpcode == OpCheck) || (bus.AHOpcode == OpMark) ||
                  (bus.AHOpcode == OpErase) || (bus.AHOpcode == OpCount);
  end

  always_ff @(posedge clk2) begin
    if (!NReset) begin
      state_q      <= StIdle;
      op_q         <= OpNop;
      blk_q        <= '0;
      start_q      <= '0;
      end_q        <= '0;
      widx_q       <= '0;
      wend_q       <= '0;
      word_q       <= '0;
      dirty_acc_q  <= 1'b0;
      cnt_acc_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      dirty_q      <= 1'b0;
      count_q      <= '0;
      os_add_q     <= '0;
      os_read_q    <= 1'b0;
      os_write_q   <= 1'b0;
      os_dataout_q <= '0;
    end else begin
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      os_read_q  <= 1'b0;
      os_write_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid && (bus.AHOpcode != OpNop)) begin
            op_q        <= bus.AHOpcode;
            blk_q       <= bus.block_address;
            start_q     <= bus.start_page;
            end_q       <= bus.end_page;
            widx_q      <= ws;
            wend_q      <= we;
            dirty_acc_q <= 1'b0;
            cnt_acc_q   <= '0;
            busy_q      <= 1'b1;
            os_add_q    <= {bus.block_address, ws};
            if (!cmd_legal || (bus.start_page > bus.end_page)) begin
              done_q  <= 1'b1;
              error_q <= 1'b1;
              state_q <= StDone;
            end else begin
              os_read_q <= 1'b1;
              state_q   <= StRdReq;
            end
          end
        end
        StRdReq:  state_q <= StRdWait;
        StRdWait: begin
          word_q  <= bus.OSDatain;
          state_q <= StEval;
        end
        StEval: begin
          dirty_acc_q <= dirty_acc_d;
          cnt_acc_q   <= cnt_acc_d;
          if (is_wb) begin
            os_dataout_q <= word_new;
            os_write_q   <= 1'b1;
            state_q      <= StWrReq;
          end else if (last_word) begin
            dirty_q <= dirty_acc_d;
            count_q <= cnt_acc_d;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            widx_q    <= widx_nxt;
            os_add_q  <= {blk_q, widx_nxt};
            os_read_q <= 1'b1;
            state_q   <= StRdReq;
          end
        end
        StWrReq:  state_q <= StWrGap;
        StWrGap: begin
          if (last_word) begin
            dirty_q <= dirty_acc_q;
            count_q <= cnt_acc_q;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            widx_q    <= widx_nxt;
            os_add_q  <= {blk_q, widx_nxt};
            os_read_q <= 1'b1;
            state_q   <= StRdReq;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Error     = error_q;
  assign bus.Dirty     = dirty_q;
  assign bus.Count     = count_q;
  assign bus.OSAdd     = os_add_q;
  assign bus.OSRead    = os_read_q;
  assign bus.OSWrite   = os_write_q;
  assign bus.OSDataout = os_dataout_q;
endmodule

// File: tb/tb_osc_bitmap_ctrl.sv
// Bench for osc_bitmap_ctrl: SRAM model, page-level reference bitmap and a Done-driven
// scoreboard monitor that checks flags, latency, access counts and memory contents.
module tb_osc_bitmap_ctrl;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned BLK_AW = 10;
  localparam int unsigned BMAP_W = WORD_W * WORDS;
  localparam int unsigned NBLK   = 16;
  localparam int unsigned MEMSZ  = 1 << (BLK_AW + 2);

  localparam logic [2:0] NOP = 3'b000, MARK = 3'b001, CHECK = 3'b010;
  localparam logic [2:0] COUNT = 3'b011, ERASE = 3'b100;

  typedef struct {
    logic err;
    logic dirty;
    int   count;
    int   lat;
    int   rd;
    int   wr;
    int   blk;
    int   acc;
  } exp_t;

  logic clk2 = 1'b0;
  logic NReset;
  always #5 clk2 = ~clk2;

  osc_bitmap_ctrl_if #(.WORD_W(WORD_W), .WORDS(WORDS), .BLK_AW(BLK_AW)) bus ();

  osc_bitmap_ctrl #(.WORD_W(WORD_W), .WORDS(WORDS), .BLK_AW(BLK_AW)) dut (
    .clk2   (clk2),
    .NReset (NReset),
    .bus    (bus.slave)
  );

  logic [WORD_W-1:0] mem [MEMSZ];
  logic [BMAP_W-1:0] ref_map [NBLK];
  exp_t sb[$];
  int   n_total = 0, n_bad = 0;
  int   cyc = 0, rd_cnt = 0, wr_cnt = 0, oor = 0, coll = 0, lo = 1, hi = 0;
  logic last_dirty = 1'b0;
  int   last_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk2) cyc++;

  // SRAM model: read data valid the cycle after OSRead.
  always @(posedge clk2) begin
    if (bus.OSRead && bus.OSWrite) coll++;
    if ((bus.OSRead || bus.OSWrite) && ((int'(bus.OSAdd) < lo) || (int'(bus.OSAdd) > hi))) oor++;
    if (bus.OSRead) begin
      rd_cnt++;
      bus.OSDatain <= mem[bus.OSAdd];
    end
    if (bus.OSWrite) begin
      wr_cnt++;
      mem[bus.OSAdd] = bus.OSDataout;
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk2);
      if (NReset === 1'b1 && bus.Done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("error", bus.Error, x.err);
          chk("latency", cyc - x.acc + 1, x.lat);
          chk("dirty", bus.Dirty, x.dirty);
          chk("count", bus.Count, x.count);
          chk("reads", rd_cnt, x.rd);
          chk("writes", wr_cnt, x.wr);
          chk("out_of_range", oor, 0);
          chk("rd_wr_overlap", coll, 0);
          for (int w = 0; w < WORDS; w++)
            chk($sformatf("mem_b%0d_w%0d", x.blk, w), mem[x.blk*WORDS + w],
                ref_map[x.blk][w*WORD_W +: WORD_W]);
          rd_cnt = 0;
          wr_cnt = 0;
          oor    = 0;
          coll   = 0;
        end
      end
    end
  end

  task automatic stop_hard(input string name);
    $display("FAIL %s: timed out waiting for DUT", name);
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  endtask

  task automatic wait_idle(input bit junk);
    int t = 0;
    @(negedge clk2);
    while (bus.Busy !== 1'b0) begin
      if (junk) begin
        bus.op_valid      = 1'($urandom_range(0, 1));
        bus.AHOpcode      = 3'($urandom);
        bus.block_address = BLK_AW'($urandom);
        bus.start_page    = 6'($urandom);
        bus.end_page      = 6'($urandom);
      end
      @(negedge clk2);
      t++;
      if (t > 400) stop_hard("busy_timeout");
    end
  endtask

  task automatic issue(input logic [2:0] op, input int blk, input int s, input int e);
    exp_t x;
    logic [BMAP_W-1:0] m;
    bit wb, legal;
    int k;
    wait_idle(1'b1);
    legal = (op == CHECK) || (op == MARK) || (op == ERASE) || (op == COUNT);
    wb    = (op == MARK) || (op == ERASE);
    if (op != NOP) begin
      x.blk = blk;
      x.acc = cyc + 1;
      if (!legal || s > e) begin
        x.err = 1'b1; x.dirty = last_dirty; x.count = last_count;
        x.lat = 1; x.rd = 0; x.wr = 0;
        lo = 1; hi = 0;
      end else begin
        m = ref_map[blk];
        x.err = 1'b0; x.dirty = 1'b0; x.count = 0;
        for (int p = s; p <= e; p++) begin
          x.dirty |= m[p];
          x.count += int'(m[p]);
          if (op == MARK)  m[p] = 1'b1;
          if (op == ERASE) m[p] = 1'b0;
        end
        ref_map[blk] = m;
        k     = e / WORD_W - s / WORD_W + 1;
        x.lat = wb ? 5 * k + 1 : 3 * k + 1;
        x.rd  = k;
        x.wr  = wb ? k : 0;
        lo    = blk * WORDS + s / WORD_W;
        hi    = blk * WORDS + e / WORD_W;
        last_dirty = x.dirty;
        last_count = x.count;
      end
      sb.push_back(x);
    end
    bus.op_valid      = 1'b1;
    bus.AHOpcode      = op;
    bus.block_address = BLK_AW'(blk);
    bus.start_page    = 6'(s);
    bus.end_page      = 6'(e);
    @(negedge clk2);
    bus.op_valid = 1'b0;
  endtask

  initial begin : stim
    int acc, s, e, t;
    logic [2:0] op;
    NReset = 1'b0;
    bus.op_valid = 1'b0; bus.AHOpcode = '0; bus.block_address = '0;
    bus.start_page = '0; bus.end_page = '0; bus.OSDatain = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
    for (int i = 0; i < NBLK; i++) ref_map[i] = '0;
    repeat (3) @(negedge clk2);
    chk("reset_ctrl", {bus.Busy, bus.Done, bus.Error, bus.Dirty, bus.OSRead, bus.OSWrite}, 0);
    chk("reset_count", bus.Count, 0);
    chk("reset_addr", bus.OSAdd, 0);
    chk("reset_wdata", bus.OSDataout, 0);
    NReset = 1'b1;

    issue(CHECK, 5, 0, 63);
    wait_idle(1'b0);
    mem[5*WORDS + 1] = 16'h0100;
    ref_map[5][WORD_W + 8] = 1'b1;
    issue(CHECK, 5, 20, 30);
    issue(MARK, 6, 14, 17);
    issue(ERASE, 6, 0, 63);
    issue(CHECK, 6, 9, 3);
    issue(3'b111, 6, 0, 5);
    issue(NOP, 6, 0, 63);

    // Reset lands in WR_GAP of word0 of a two-word MARK.
    wait_idle(1'b0);
    lo = 9 * WORDS; hi = 9 * WORDS + 1;
    bus.op_valid = 1'b1; bus.AHOpcode = MARK; bus.block_address = BLK_AW'(9);
    bus.start_page = 6'd14; bus.end_page = 6'd17;
    acc = cyc + 1;
    @(negedge clk2);
    bus.op_valid = 1'b0;
    t = 0;
    while (cyc < acc + 3 && t < 10) begin
      @(negedge clk2);
      t++;
    end
    chk("mid_wr_req", bus.OSWrite, 1);
    @(negedge clk2);
    chk("mid_wr_gap", {bus.OSWrite, bus.Busy}, 2'b01);
    NReset = 1'b0;
    @(negedge clk2);
    chk("mid_rst_ctrl", {bus.Busy, bus.Done, bus.Error, bus.Dirty, bus.OSRead, bus.OSWrite}, 0);
    chk("mid_rst_count", bus.Count, 0);
    chk("mid_rst_addr", bus.OSAdd, 0);
    chk("mid_rst_wdata", bus.OSDataout, 0);
    NReset = 1'b1;
    repeat (2) @(negedge clk2);
    chk("mid_rst_word0", mem[9*WORDS], 16'hC000);
    chk("mid_rst_word1", mem[9*WORDS + 1], 16'h0000);
    chk("mid_rst_no_strobe", wr_cnt, 1);
    ref_map[9][15:14] = 2'b11;
    last_dirty = 1'b0; last_count = 0;
    rd_cnt = 0; wr_cnt = 0; oor = 0; coll = 0;
    issue(CHECK, 9, 0, 63);

    wait_idle(1'b0);
    for (int b = 0; b < NBLK; b++)
      for (int w = 0; w < WORDS; w++) begin
        mem[b*WORDS + w] = WORD_W'($urandom);
        ref_map[b][w*WORD_W +: WORD_W] = mem[b*WORDS + w];
      end

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = CHECK;
        2, 3:    op = MARK;
        4, 5:    op = ERASE;
        6, 7:    op = COUNT;
        8:       op = NOP;
        default: op = 3'(5 + $urandom_range(0, 2));
      endcase
      s = int'($urandom_range(0, BMAP_W - 1));
      e = int'($urandom_range(0, BMAP_W - 1));
      case ($urandom_range(0, 9))
        0:       begin s = 0; e = BMAP_W - 1; end
        1:       e = s;
        2:       ;
        default: if (s > e) begin t = s; s = e; e = t; end
      endcase
      issue(op, int'($urandom_range(0, NBLK - 1)), s, e);
    end

    wait_idle(1'b0);
    repeat (3) @(negedge clk2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
